// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One product or quotient bit per cycle; signed ops are fixed up after iterating.
module mips_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] p;
   logic [WIDTH-1:0]   d;
   logic [CW-1:0]      cnt;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;

   logic               op_mul;
   logic               op_div;
   logic               op_mt;
   logic               b_zero;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   assign op_mul = (op[2:1] == 2'b00);
   assign op_div = (op[2:1] == 2'b01);
   assign op_mt  = (op[2:1] == 2'b10);
   assign b_zero = (b == '0);
   assign a_neg  = op[0] & a[WIDTH-1];
   assign b_neg  = op[0] & b[WIDTH-1];
   assign a_mag  = a_neg ? -a : a;
   assign b_mag  = b_neg ? -b : b;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_t;
   logic [WIDTH:0]     div_sub;
   logic [2*WIDTH-1:0] mul_nxt;
   logic [2*WIDTH-1:0] div_nxt;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   // upper half is the accumulator / partial remainder, lower half the
   // multiplier / dividend bits being consumed
   assign mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, d};
   assign mul_nxt = p[0] ? {mul_sum, p[WIDTH-1:1]}
                         : {1'b0, p[2*WIDTH-1:1]};
   assign div_t   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
   assign div_sub = div_t - {1'b0, d};
   assign div_nxt = div_sub[WIDTH]
                  ? {div_t[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                  : {div_sub[WIDTH-1:0], p[WIDTH-2:0], 1'b1};

   assign prod = neg_q ? -p : p;
   assign quo  = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
   assign rem  = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         p        <= '0;
         d        <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     unique case (1'b1)
                        op_mt: begin
                           if (op[0]) lo <= a;
                           else       hi <= a;
                           done <= 1'b1;
                        end
                        op_div && b_zero: begin
                           done     <= 1'b1;
                           div_zero <= 1'b1;
                        end
                        op_mul || (op_div && !b_zero): begin
                           is_div <= op_div;
                           neg_q  <= a_neg ^ b_neg;
                           neg_r  <= a_neg;
                           cnt    <= '0;
                           p      <= {{WIDTH{1'b0}}, op_div ? a_mag : b_mag};
                           d      <= op_div ? b_mag : a_mag;
                           busy   <= 1'b1;
                           state  <= ITER;
                        end
                        default: ;
                     endcase
                  end
               end
               ITER: begin
                  p   <= is_div ? div_nxt : mul_nxt;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) state <= FIX;
               end
               FIX: begin
                  if (is_div) {hi, lo} <= {rem, quo};
                  else        {hi, lo} <= prod;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: vector table through a result scoreboard,
// plus directed back-to-back, flush, reset and WIDTH=8 sequences.
module tb_mips_muldiv;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op    = '0;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   logic        start8 = 1'b0;
   logic        flush8 = 1'b0;
   logic [2:0]  op8    = '0;
   logic [7:0]  a8     = '0;
   logic [7:0]  b8     = '0;
   logic        busy8;
   logic        done8;
   logic        dz8;
   logic [7:0]  hi8;
   logic [7:0]  lo8;

   always #5 clock = ~clock;

   mips_muldiv #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .flush(flush),
      .op(op), .a(a), .b(b), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   mips_muldiv #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .flush(flush8),
      .op(op8), .a(a8), .b(b8), .busy(busy8), .done(done8),
      .div_zero(dz8), .hi(hi8), .lo(lo8)
   );

   exp_t        sb[$];
   vec_t        tv[$];
   int          n_pass = 0;
   int          n_tot  = 0;
   logic [31:0] sh_hi  = '0;
   logic [31:0] sh_lo  = '0;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   function automatic exp_t model(input logic [2:0] o,
                                  input logic [31:0] x, input logic [31:0] y);
      exp_t        r;
      logic [63:0] pr;
      longint      sx, sy, q, m;
      r  = '{32'd0, 32'd0, 1'b0};
      sx = $signed(x);
      sy = $signed(y);
      case (o)
         3'd0: begin
            pr = {32'd0, x} * {32'd0, y};
            r.hi = pr[63:32]; r.lo = pr[31:0];
         end
         3'd1: begin
            pr = sx * sy;
            r.hi = pr[63:32]; r.lo = pr[31:0];
         end
         3'd2: begin
            r.lo = x / y; r.hi = x % y;
         end
         3'd3: begin
            q = sx / sy; m = sx % sy;
            r.lo = q[31:0]; r.hi = m[31:0];
         end
         default: ;
      endcase
      return r;
   endfunction

   // scoreboard consumer: every done pulse must match the oldest expectation
   always @(negedge clock) begin
      exp_t e;
      if (!reset && done) begin
         if (sb.size() == 0) begin
            n_tot++;
            $display("FAIL unexpected_done: got done=1 expected no done");
         end else begin
            e = sb.pop_front();
            check("sb_hi", hi, e.hi);
            check("sb_lo", lo, e.lo);
            check("sb_div_zero", div_zero, e.dz);
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit push, input exp_t e);
      start = 1'b1; op = o; a = x; b = y;
      if (push) sb.push_back(e);
      @(negedge clock);
      start = 1'b0;
      op = 3'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 100) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic run(input vec_t v, input string name);
      exp_t e;
      int   lat;
      int   elat;
      e    = '{v.hi, v.lo, v.dz};
      elat = (!v.op[2] && !v.dz) ? 33 : 0;
      issue(v.op, v.a, v.b, 1'b1, e);
      wait_done(lat);
      check({name, "_latency"}, lat, elat);
      @(negedge clock);
      sh_hi = v.hi;
      sh_lo = v.lo;
   endtask

   task automatic run8(input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] eh,
                       input logic [7:0] el, input string name);
      int lat;
      start8 = 1'b1; op8 = o; a8 = x; b8 = y;
      @(negedge clock);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      while (!done8 && lat < 50) begin
         @(negedge clock);
         lat++;
      end
      check({name, "_latency"}, lat, 9);
      check({name, "_hi"}, hi8, eh);
      check({name, "_lo"}, lo8, el);
      check({name, "_div_zero"}, dz8, 1'b0);
      @(negedge clock);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      exp_t        e;
      vec_t        v;
      int          lat;
      int          nd;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      repeat (3) @(negedge clock);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_div_zero", div_zero, 1'b0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy8", busy8, 1'b0);
      reset = 1'b0;
      @(negedge clock);

      tv.push_back('{3'd4, 32'd5,        32'd0,        32'd5,        32'd0,        1'b0});
      tv.push_back('{3'd5, 32'd9,        32'd0,        32'd5,        32'd9,        1'b0});
      tv.push_back('{3'd2, 32'd100,      32'd0,        32'd5,        32'd9,        1'b1});
      tv.push_back('{3'd3, 32'hFFFFFFF0, 32'd0,        32'd5,        32'd9,        1'b1});
      tv.push_back('{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0});
      tv.push_back('{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
      tv.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0});
      tv.push_back('{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0});
      tv.push_back('{3'd2, 32'd7,        32'hFFFFFFFF, 32'd7,        32'd0,        1'b0});
      tv.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0});
      tv.push_back('{3'd0, 32'd0,        32'h12345678, 32'd0,        32'd0,        1'b0});
      for (int k = 0; k < 16; k++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if (k % 4 == 0) rb = rb >> 24;
         if (ro[1] && rb == 0) rb = 32'd1;
         e = model(ro, ra, rb);
         tv.push_back('{ro, ra, rb, e.hi, e.lo, 1'b0});
      end
      for (int i = 0; i < tv.size(); i++) begin
         v = tv[i];
         run(v, $sformatf("vec%0d", i));
      end

      // back-to-back: second op issued in the done cycle
      issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
            '{32'hFFFFFFFE, 32'h00000001, 1'b0});
      wait_done(lat);
      check("b2b_first_latency", lat, 33);
      check("b2b_done_cycle_busy", busy, 1'b0);
      issue(3'd0, 32'd6, 32'd7, 1'b1, '{32'd0, 32'd42, 1'b0});
      check("b2b_busy_next", busy, 1'b1);
      wait_done(lat);
      check("b2b_second_latency", lat, 33);
      @(negedge clock);

      // flush mid multiply
      run('{3'd4, 32'h1234, 32'd0, 32'h1234, 32'd42, 1'b0}, "pre_mthi");
      run('{3'd5, 32'h5678, 32'd0, 32'h1234, 32'h5678, 1'b0}, "pre_mtlo");
      issue(3'd0, 32'd6, 32'd7, 1'b0, '{32'd0, 32'd0, 1'b0});
      repeat (9) @(negedge clock);
      check("flush_busy_before", busy, 1'b1);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("flush_busy_after", busy, 1'b0);
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) nd++;
         @(negedge clock);
      end
      check("flush_no_done", nd, 0);
      check("flush_hi", hi, sh_hi);
      check("flush_lo", lo, sh_lo);

      // flush beats a simultaneous start
      flush = 1'b1;
      issue(3'd4, 32'hDEAD, 32'd0, 1'b0, '{32'd0, 32'd0, 1'b0});
      flush = 1'b0;
      check("flush_start_done", done, 1'b0);
      check("flush_start_busy", busy, 1'b0);
      check("flush_start_hi", hi, sh_hi);

      // illegal ops are ignored
      issue(3'd6, 32'hAAAA, 32'd3, 1'b0, '{32'd0, 32'd0, 1'b0});
      check("illegal6_busy", busy, 1'b0);
      check("illegal6_done", done, 1'b0);
      issue(3'd7, 32'hBBBB, 32'd3, 1'b0, '{32'd0, 32'd0, 1'b0});
      check("illegal7_busy", busy, 1'b0);
      repeat (3) @(negedge clock);
      check("illegal_hi", hi, sh_hi);
      check("illegal_lo", lo, sh_lo);

      // asynchronous reset in the middle of a divide
      issue(3'd2, 32'd1000, 32'd3, 1'b0, '{32'd0, 32'd0, 1'b0});
      repeat (5) @(negedge clock);
      check("rstmid_busy_before", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("rstmid_hi", hi, 32'd0);
      check("rstmid_lo", lo, 32'd0);
      check("rstmid_busy", busy, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      sh_hi = '0;
      sh_lo = '0;
      @(negedge clock);
      e = model(3'd2, 32'd1000, 32'd3);
      run('{3'd2, 32'd1000, 32'd3, e.hi, e.lo, 1'b0}, "post_rst_divu");

      run8(3'd2, 8'd200, 8'd7, 8'd4, 8'd28, "w8_divu");
      run8(3'd1, 8'hFD, 8'd5, 8'hFF, 8'hF1, "w8_mult");
      run8(3'd3, 8'h80, 8'hFF, 8'h00, 8'h80, "w8_div_ovf");

      repeat (2) @(negedge clock);
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
